// File: rtl/ikaopll_pkg.sv
// Shared types and helpers for the OPLL register write scheduler.
package ikaopll_pkg;

    localparam int unsigned NUM_SLOTS  = 18;
    localparam int unsigned NUM_CH     = 9;
    localparam int unsigned REG_ADDR_W = 6;
    localparam int unsigned REG_DATA_W = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } reg_wr_t;

    typedef enum logic [1:0] {
        HEAD_EMPTY     = 2'd0,
        HEAD_WAIT_SLOT = 2'd1,
        HEAD_COMMIT    = 2'd2
    } head_state_e;

    // Globals 0x00-0x07/0x0E/0x0F plus three 9-channel banks at 0x10/0x20/0x30.
    function automatic logic addr_valid(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        if (d[7:6] == 2'b00) begin
            case (d[5:4])
                2'b00:   ok = (d[3:0] <= 4'h7) || (d[3:0] >= 4'hE);
                default: ok = (d[3:0] < 4'(NUM_CH));
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/ikaopll_reg_write_sched_if.sv
// CPU bus write side and register-file commit side of the scheduler.
interface ikaopll_reg_write_sched_if;
    import ikaopll_pkg::*;

    logic                  i_CS_n;
    logic                  i_WR_n;
    logic                  i_A0;
    logic [7:0]            i_D;
    logic                  o_REG_WE;
    logic [REG_ADDR_W-1:0] o_REG_ADDR;
    logic [REG_DATA_W-1:0] o_REG_DATA;

    modport master (
        output i_CS_n, i_WR_n, i_A0, i_D,
        input  o_REG_WE, o_REG_ADDR, o_REG_DATA
    );

    modport slave (
        input  i_CS_n, i_WR_n, i_A0, i_D,
        output o_REG_WE, o_REG_ADDR, o_REG_DATA
    );

endinterface

// File: rtl/ikaopll_wrfifo.sv
// In-order pending-write FIFO; a pop on the same enable frees room for a push when full.
module ikaopll_wrfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_c_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = cen_i & pop_i & ~empty_q;
        do_push  = cen_i & push_i & (~full_q | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + LW'(do_push) - LW'(do_pop);
        full_d   = (cnt_d == LW'(DEPTH));
        empty_d  = (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_c_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = cnt_q;

endmodule

// File: rtl/ikaopll_reg_write_sched.sv
// Validates CPU register writes, queues them and commits each in the datapath slot
// of its channel (globals commit at once) so no channel sees a mid-slot change.
module ikaopll_reg_write_sched
    import ikaopll_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned CHAN_SLOT_OFS = 0
) (
    input  logic                   i_EMUCLK,
    input  logic                   i_RST,
    input  logic                   i_phi1_NCEN_n,
    input  logic                   i_CYCLE_00,
    input  logic                   i_OVF_CLR,
    ikaopll_reg_write_sched_if.slave bus_if,
    output logic                   o_BUSY,
    output logic [$clog2(DEPTH):0] o_FIFO_LVL,
    output logic                   o_OVERFLOW,
    output logic                   o_SYNCED
);

    localparam int unsigned SLOT_W = 5;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WORD_W = $bits(reg_wr_t);

    logic                  tick_c, wr_act_c, wr_evt_c, addr_wr_c, data_wr_c;
    logic                  head_global_c, head_ready_c, commit_c, ovf_set_c;
    logic [5:0]            slot_sum_c;
    logic [SLOT_W-1:0]     slot_tgt_c;
    logic [WORD_W-1:0]     fifo_rdata_c;
    reg_wr_t               head_c, push_rec_c;
    logic                  fifo_full, fifo_empty;
    logic [LVL_W-1:0]      fifo_lvl;

    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  synced_q, synced_d;
    logic                  wr_act_q, wr_act_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic                  addr_vld_q, addr_vld_d;
    logic                  ovf_q, ovf_d;
    head_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [REG_DATA_W-1:0] reg_data_q, reg_data_d;

    assign tick_c    = ~i_phi1_NCEN_n;
    assign wr_act_c  = ~bus_if.i_CS_n & ~bus_if.i_WR_n;
    assign wr_evt_c  = tick_c & wr_act_c & ~wr_act_q;
    assign addr_wr_c = wr_evt_c & ~bus_if.i_A0;
    assign data_wr_c = wr_evt_c & bus_if.i_A0 & addr_vld_q;

    assign push_rec_c.addr = addr_q;
    assign push_rec_c.data = bus_if.i_D;
    assign head_c          = reg_wr_t'(fifo_rdata_c);

    // Channel c owns slot (c + CHAN_SLOT_OFS) mod 18.
    assign slot_sum_c    = 6'(head_c.addr[3:0]) + 6'(CHAN_SLOT_OFS);
    assign slot_tgt_c    = (slot_sum_c >= 6'(NUM_SLOTS)) ? SLOT_W'(slot_sum_c - 6'(NUM_SLOTS))
                                                         : SLOT_W'(slot_sum_c);
    assign head_global_c = (head_c.addr[5:4] == 2'b00);
    assign head_ready_c  = head_global_c | (synced_q & (slot_q == slot_tgt_c));
    assign commit_c      = tick_c & ~fifo_empty & head_ready_c;
    assign ovf_set_c     = data_wr_c & fifo_full & ~commit_c;

    ikaopll_wrfifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_wrfifo (
        .clk       (i_EMUCLK),
        .rst       (i_RST),
        .cen_i     (tick_c),
        .push_i    (data_wr_c),
        .wdata_i   (push_rec_c),
        .pop_i     (commit_c),
        .rdata_c_o (fifo_rdata_c),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_lvl)
    );

    always_comb begin
        slot_d     = slot_q;
        synced_d   = synced_q;
        wr_act_d   = wr_act_q;
        addr_d     = addr_q;
        addr_vld_d = addr_vld_q;
        ovf_d      = ovf_q;
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        if (tick_c) begin
            if (i_CYCLE_00) begin
                slot_d   = SLOT_W'(1);
                synced_d = 1'b1;
            end else begin
                slot_d = (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + SLOT_W'(1);
            end
            wr_act_d = wr_act_c;
            if (addr_wr_c) begin
                addr_d     = bus_if.i_D[5:0];
                addr_vld_d = addr_valid(bus_if.i_D);
            end
            if (ovf_set_c)      ovf_d = 1'b1;
            else if (i_OVF_CLR) ovf_d = 1'b0;
            // Head FSM: COMMIT holds the write strobe for exactly one tick period.
            if (commit_c) begin
                state_d    = HEAD_COMMIT;
                reg_addr_d = head_c.addr;
                reg_data_d = head_c.data;
            end else if (!fifo_empty) begin
                state_d = HEAD_WAIT_SLOT;
            end else begin
                state_d = HEAD_EMPTY;
            end
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            slot_q     <= '0;
            synced_q   <= 1'b0;
            wr_act_q   <= 1'b0;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= HEAD_EMPTY;
            reg_addr_q <= '0;
            reg_data_q <= '0;
        end else begin
            slot_q     <= slot_d;
            synced_q   <= synced_d;
            wr_act_q   <= wr_act_d;
            addr_q     <= addr_d;
            addr_vld_q <= addr_vld_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
        end
    end

    assign bus_if.o_REG_WE   = (state_q == HEAD_COMMIT);
    assign bus_if.o_REG_ADDR = reg_addr_q;
    assign bus_if.o_REG_DATA = reg_data_q;
    assign o_BUSY            = fifo_full;
    assign o_FIFO_LVL        = fifo_lvl;
    assign o_OVERFLOW        = ovf_q;
    assign o_SYNCED          = synced_q;

endmodule
